// File: rtl/iter_shift_if.sv
// Bus bundle for iter_shift_unit: operand/request signals and result/status signals.
//
// Optional macro: ITER_SHIFT_CARRY_EN adds the carry_out signal.
//
// Signals:
//   start     request pulse, sampled by the unit only when it is idle or done
//   op        3-bit operation select (SHR, SHRA, SHL, ROR, ROL, 101-111 pass-through)
//   data_in   operand to shift
//   amount    unsigned shift count
//   result    shifted value, held after done
//   busy      high while the unit is shifting
//   done      one-cycle pulse when result is valid
//   carry_out last bit shifted/rotated out (only with ITER_SHIFT_CARRY_EN)
//
// Modports: master drives requests (controller side), slave is the shift unit.
interface iter_shift_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] amount;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

`ifdef ITER_SHIFT_CARRY_EN
    logic             carry_out;

    modport master (
        output start, op, data_in, amount,
        input  result, busy, done, carry_out
    );
    modport slave (
        input  start, op, data_in, amount,
        output result, busy, done, carry_out
    );
`else
    modport master (
        output start, op, data_in, amount,
        input  result, busy, done
    );
    modport slave (
        input  start, op, data_in, amount,
        output result, busy, done
    );
`endif
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL and pass-through, shifting at
// most STEP bit positions per clock. Operands are captured on start; done pulses for one
// cycle when the result is valid, and the result is held until the next operation shifts.
//
// Optional macro: ITER_SHIFT_CARRY_EN adds bus.carry_out (last bit shifted/rotated out).
//
// Parameters:
//   WIDTH  operand/result width (power of 2, >= 8)
//   STEP   maximum bit positions shifted per cycle (1..WIDTH)
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   clr    synchronous active-high reset; abandons any operation without a done pulse
//   bus    iter_shift_if slave modport (start/op/data_in/amount in, result/busy/done out)
module iter_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input logic        clk,
    input logic        clr,
    iter_shift_if.slave bus
);

    localparam int unsigned AW = $clog2(WIDTH);
    localparam int unsigned CW = AW + 1;    // counts 0..WIDTH inclusive

    localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    CntWidth = CW'(WIDTH);
    localparam logic [CW-1:0]    CntStep  = CW'(STEP);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    remaining_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    n_load;
    logic [CW-1:0]    k;
    logic [CW-1:0]    inv_k;
    logic [WIDTH-1:0] shift_next;

    // Effective count captured at load.
    always_comb begin
        n_load = '0;
        case (bus.op)
            3'b000, 3'b001, 3'b010: begin
                n_load = (bus.amount >= WidthVal) ? CntWidth : bus.amount[CW-1:0];
            end
            3'b011, 3'b100: begin
                n_load = {1'b0, bus.amount[AW-1:0]};
            end
            default: n_load = '0;
        endcase
    end

    // k is zero once the count is exhausted, so the final SHIFT edge copies work_q as-is.
    // A shift by WIDTH yields 0, which makes the rotate wrap term vanish for k = 0.
    always_comb begin
        k          = (remaining_q > CntStep) ? CntStep : remaining_q;
        inv_k      = CntWidth - k;
        shift_next = work_q;
        case (op_q)
            3'b000:  shift_next = work_q >> k;
            3'b001:  shift_next = $signed(work_q) >>> k;
            3'b010:  shift_next = work_q << k;
            3'b011:  shift_next = (work_q >> k) | (work_q << inv_k);
            3'b100:  shift_next = (work_q << k) | (work_q >> inv_k);
            default: shift_next = work_q;
        endcase
    end

`ifdef ITER_SHIFT_CARRY_EN
    logic          carry_q;
    logic          shift_carry;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] l_idx;

    // Right moves lose bit k-1, left moves lose bit WIDTH-k; only meaningful for k != 0.
    always_comb begin
        r_idx       = AW'(k - CW'(1));
        l_idx       = AW'(inv_k);
        shift_carry = 1'b0;
        case (op_q)
            3'b000, 3'b001, 3'b011: shift_carry = work_q[r_idx];
            3'b010, 3'b100:         shift_carry = work_q[l_idx];
            default:                shift_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            carry_q <= 1'b0;
        end else if ((state_q == StIdle || state_q == StDone) && bus.start) begin
            carry_q <= 1'b0;
        end else if (state_q == StShift && k != '0) begin
            carry_q <= shift_carry;
        end
    end

    assign bus.carry_out = carry_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            work_q      <= '0;
            result_q    <= '0;
            op_q        <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work_q      <= bus.data_in;
                        op_q        <= bus.op;
                        remaining_q <= n_load;
                        busy_q      <= 1'b1;
                        state_q     <= StShift;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    work_q   <= shift_next;
                    result_q <= shift_next;
                    if (remaining_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        remaining_q <= remaining_q - k;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: two instances (STEP=1 and STEP=4) share clock and clear.
// A vector table with hand-derived results is applied to both; a negedge monitor pops the
// expected result, carry and done cycle from a per-instance queue on every done pulse.
// Hand-written sequences cover busy timing, start while busy, start in DONE and clr abort.
module tb_iter_shift_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    iter_shift_if #(.WIDTH(W)) a_if ();
    iter_shift_if #(.WIDTH(W)) b_if ();

    iter_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
        .clk (clk),
        .clr (clr),
        .bus (a_if.slave)
    );

    iter_shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk (clk),
        .clr (clr),
        .bus (b_if.slave)
    );

    logic car_a;
    logic car_b;
`ifdef ITER_SHIFT_CARRY_EN
    assign car_a = a_if.carry_out;
    assign car_b = b_if.carry_out;
`else
    assign car_a = 1'b0;
    assign car_b = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        carry;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] amt;
        int          n;
        logic [31:0] res;
        logic        carry;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial forever @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input int which);
        logic        d;
        logic [31:0] r;
        logic        c;
        int          qs;
        exp_t        e;
        string       tag;
        tag = (which == 0) ? "step1" : "step4";
        if (which == 0) begin
            d = a_if.done; r = a_if.result; c = car_a; qs = q_a.size();
        end else begin
            d = b_if.done; r = b_if.result; c = car_b; qs = q_b.size();
        end
        if (d === 1'b1) begin
            if (qs == 0) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected_done: got done=1 required done=0 (cycle %0d)",
                         tag, cyc);
            end else begin
                e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
                check({tag, " result"}, r, e.res);
                check({tag, " done_cycle"}, 32'(cyc), 32'(e.done_cyc));
`ifdef ITER_SHIFT_CARRY_EN
                check({tag, " carry_out"}, 32'(c), 32'(e.carry));
`endif
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_one(0);
        mon_one(1);
    end

    // Call right after a negedge; the following posedge is the start edge t.
    task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] amt,
                         input int n, input logic [31:0] er, input logic ec,
                         input bit to_a, input bit to_b, input bit accept);
        exp_t e;
        int   t;
        t       = cyc + 1;
        e.res   = er;
        e.carry = ec;
        if (to_a) begin
            a_if.start = 1'b1; a_if.op = op; a_if.data_in = d; a_if.amount = amt;
            if (accept) begin
                e.done_cyc = t + 1 + n;
                q_a.push_back(e);
            end
        end
        if (to_b) begin
            b_if.start = 1'b1; b_if.op = op; b_if.data_in = d; b_if.amount = amt;
            if (accept) begin
                e.done_cyc = t + 1 + (n + 3) / 4;
                q_b.push_back(e);
            end
        end
        @(negedge clk);
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        // Operands are captured at the start edge; later changes must not matter.
        a_if.op = 3'($urandom); a_if.data_in = $urandom; a_if.amount = $urandom;
        b_if.op = 3'($urandom); b_if.data_in = $urandom; b_if.amount = $urandom;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        if (i == bound) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout: got %0d/%0d pending required 0/0",
                     q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    vec_t vecs[15];
    bit   seen;

    initial begin
        vecs[0]  = '{3'b001, 32'hF000_0022, 32'd2,          2,  32'hFC00_0008, 1'b1};
        vecs[1]  = '{3'b010, 32'h0000_0026, 32'd5,          5,  32'h0000_04C0, 1'b0};
        vecs[2]  = '{3'b011, 32'h8000_0001, 32'd33,         1,  32'hC000_0000, 1'b1};
        vecs[3]  = '{3'b100, 32'h8000_0001, 32'd32,         0,  32'h8000_0001, 1'b0};
        vecs[4]  = '{3'b000, 32'hA5A5_A5A5, 32'hFFFF_FFFF,  32, 32'h0000_0000, 1'b1};
        vecs[5]  = '{3'b001, 32'h8000_0000, 32'd40,         32, 32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{3'b010, 32'h0000_0001, 32'd32,         32, 32'h0000_0000, 1'b1};
        vecs[7]  = '{3'b100, 32'h1234_5678, 32'd4,          4,  32'h2345_6781, 1'b1};
        vecs[8]  = '{3'b011, 32'h1234_5678, 32'd12,         12, 32'h6781_2345, 1'b0};
        vecs[9]  = '{3'b000, 32'h8000_0000, 32'd7,          7,  32'h0100_0000, 1'b0};
        vecs[10] = '{3'b001, 32'h7FFF_FFFF, 32'd3,          3,  32'h0FFF_FFFF, 1'b1};
        vecs[11] = '{3'b101, 32'hDEAD_BEEF, 32'd5,          0,  32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{3'b111, 32'h0BAD_F00D, 32'd0,          0,  32'h0BAD_F00D, 1'b0};
        vecs[13] = '{3'b010, 32'h8000_0001, 32'd0,          0,  32'h8000_0001, 1'b0};
        vecs[14] = '{3'b000, 32'hFFFF_FFFF, 32'd31,         31, 32'h0000_0001, 1'b1};

        a_if.start = 1'b0; a_if.op = '0; a_if.data_in = '0; a_if.amount = '0;
        b_if.start = 1'b0; b_if.op = '0; b_if.data_in = '0; b_if.amount = '0;

        // Reset state
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("reset result", a_if.result, 32'h0);
        check("reset busy", 32'(a_if.busy), 32'h0);
        check("reset done", 32'(a_if.done), 32'h0);
        check("reset result step4", b_if.result, 32'h0);
`ifdef ITER_SHIFT_CARRY_EN
        check("reset carry", 32'(car_a), 32'h0);
`endif
        clr = 1'b0;
        @(negedge clk);

        // Table vectors on both instances
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].n, vecs[i].res,
                  vecs[i].carry, 1'b1, 1'b1, 1'b1);
            wait_idle(100);
            @(negedge clk);
        end

        // Busy/done profile of SHRA by 2 at STEP=1: busy after edges t..t+2, done after t+3
        issue(3'b001, 32'hF000_0022, 32'd2, 2, 32'hFC00_0008, 1'b1, 1'b1, 1'b0, 1'b1);
        check("busy after t", 32'(a_if.busy), 32'h1);
        check("done after t", 32'(a_if.done), 32'h0);
        @(negedge clk);
        check("busy after t+1", 32'(a_if.busy), 32'h1);
        @(negedge clk);
        check("busy after t+2", 32'(a_if.busy), 32'h1);
        check("done after t+2", 32'(a_if.done), 32'h0);
        @(negedge clk);
        check("busy after t+3", 32'(a_if.busy), 32'h0);
        check("done after t+3", 32'(a_if.done), 32'h1);
        @(negedge clk);
        check("done after t+4", 32'(a_if.done), 32'h0);
        check("result held", a_if.result, 32'hFC00_0008);
        wait_idle(10);
        repeat (2) @(negedge clk);

        // Start during SHIFT is ignored and not queued
        issue(3'b000, 32'hFFFF_FFFF, 32'd8, 8, 32'h00FF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        issue(3'b100, 32'h1234_5678, 32'd3, 3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(40);
        repeat (12) @(negedge clk);
        check("idle after ignored start", 32'(a_if.busy), 32'h0);

        // Start during DONE is accepted back-to-back
        issue(3'b010, 32'h0000_0003, 32'd1, 1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (a_if.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done seen for back-to-back", 32'(seen), 32'h1);
        if (seen) begin
            issue(3'b011, 32'h0000_00F0, 32'd5, 5, 32'h8000_0007, 1'b1, 1'b1, 1'b0, 1'b1);
            check("busy after start in DONE", 32'(a_if.busy), 32'h1);
            check("result held over load edge", a_if.result, 32'h0000_0006);
        end
        wait_idle(40);
        repeat (2) @(negedge clk);

        // clr mid-SHIFT abandons the operation with no done pulse
        issue(3'b000, 32'hFFFF_FFFF, 32'd20, 20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr result", a_if.result, 32'h0);
        check("clr busy", 32'(a_if.busy), 32'h0);
        check("clr done", 32'(a_if.done), 32'h0);
        issue(3'b110, 32'h1234_5678, 32'd9, 0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle(10);
        repeat (25) @(negedge clk);
        check("idle at end", 32'(a_if.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
